// File: rtl/fft_frame_ctrl_pkg.sv
// Shared constants for the FFT frame sequencer: default FFT geometry and
// controller state encodings, plus the in-flight frame bookkeeping helper.
// Imported by the interface, the frame counter and the controller top.
package fft_frame_ctrl_pkg;

    // Default FFT geometry: log2 of the FFT length, and complex sample width {re, im}.
    localparam int TOTAL_STAGE = 8;
    localparam int CPLX_WIDTH  = 32;

    // Controller state encodings.
    localparam logic [1:0] FFTC_IDLE  = 2'd0;
    localparam logic [1:0] FFTC_RUN   = 2'd1;
    localparam logic [1:0] FFTC_DRAIN = 2'd2;

    // Frames-in-flight update.
    // - A frame entering and a frame leaving in the same cycle cancel out.
    // - A leaving frame never drives the count below zero. Output beats can
    //   still arrive while the controller has nothing outstanding.
    function automatic logic [2:0] inflight_next(input logic [2:0] cur,
                                                 input logic       inc,
                                                 input logic       dec);
        logic [2:0] r;
        r = cur;
        if (inc && !dec) begin
            r = cur + 3'd1;
        end else if (dec && !inc && (cur != 3'd0)) begin
            r = cur - 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Sample stream and FFT datapath bundle seen by the frame sequencer.
// Port summary:
//   s_valid/s_ready/s_data          : input sample stream
//   fft_ien/fft_iaddr/fft_idata     : FFT input side
//   fft_oen/fft_oaddr               : FFT output side
// slave modport  = the controller.
// master modport = the environment (source and FFT).
interface fft_frame_ctrl_if
    import fft_frame_ctrl_pkg::*;
#(
    parameter int STAGES = TOTAL_STAGE,
    parameter int CPLX_W = CPLX_WIDTH
);
    logic              s_valid;
    logic              s_ready;
    logic [CPLX_W-1:0] s_data;
    logic              fft_ien;
    logic [STAGES-1:0] fft_iaddr;
    logic [CPLX_W-1:0] fft_idata;
    logic              fft_oen;
    logic [STAGES-1:0] fft_oaddr;

    modport slave (
        input  s_valid, s_data, fft_oen, fft_oaddr,
        output s_ready, fft_ien, fft_iaddr, fft_idata
    );

    modport master (
        output s_valid, s_data, fft_oen, fft_oaddr,
        input  s_ready, fft_ien, fft_iaddr, fft_idata
    );
endinterface

// File: rtl/fft_frame_cnt.sv
// Purpose: STAGES-bit wrapping beat counter within an N-point frame.
// Latency: count updates at the edge that samples inc; last is combinational from the count.
// Backpressure: none; the counter advances on every cycle where inc is high.
// Ports: iclk, rst_n (async active-low), inc, cnt (current index), last (cnt == N-1).
module fft_frame_cnt
    import fft_frame_ctrl_pkg::*;
#(
    parameter int STAGES = TOTAL_STAGE
) (
    input  logic              iclk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [STAGES-1:0] cnt,
    output logic              last
);
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == {STAGES{1'b1}});
endmodule

// File: rtl/fft_frame_ctrl.sv
// Purpose: packs a valid/ready sample stream into N-point FFT frames and tracks frames in flight.
// Latency: 1 cycle from an accepted sample to fft_ien/fft_iaddr/fft_idata.
// Backpressure: s_ready drops only at a frame boundary, when the pipeline is full or a stop is pending.
// Ports: iclk, rst_n, start/stop pulses, bus (slave side of fft_frame_ctrl_if),
//        busy, inflight, frame_done, frames_out, err_order.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int STAGES       = TOTAL_STAGE,
    parameter int CPLX_W       = CPLX_WIDTH,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic             iclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    fft_frame_ctrl_if.slave  bus,
    output logic             busy,
    output logic [2:0]       inflight,
    output logic             frame_done,
    output logic [15:0]      frames_out,
    output logic             err_order
);
    logic [1:0]        state;
    logic              stop_pend;
    logic [STAGES-1:0] in_cnt;
    logic [STAGES-1:0] out_cnt;
    logic              in_last;
    logic              out_last;
    logic              s_rdy;
    logic              accept;
    logic              in_done;
    logic              out_done;
    logic              at_cap;

    // s_ready depends only on registered state.
    // - Throttling applies only before the first beat of a frame.
    // - A frame that has started is always completed.
    assign at_cap   = (inflight == 3'(MAX_INFLIGHT));
    assign s_rdy    = (state == FFTC_RUN) && !((in_cnt == '0) && (at_cap || stop_pend));
    assign accept   = bus.s_valid && s_rdy;
    assign in_done  = accept && in_last;
    assign out_done = bus.fft_oen && out_last;

    assign bus.s_ready = s_rdy;
    assign busy        = (state != FFTC_IDLE);

    fft_frame_cnt #(.STAGES(STAGES)) u_in_cnt (
        .iclk  (iclk),
        .rst_n (rst_n),
        .inc   (accept),
        .cnt   (in_cnt),
        .last  (in_last)
    );

    // Output beats are counted in every state, including IDLE.
    fft_frame_cnt #(.STAGES(STAGES)) u_out_cnt (
        .iclk  (iclk),
        .rst_n (rst_n),
        .inc   (bus.fft_oen),
        .cnt   (out_cnt),
        .last  (out_last)
    );

    // Control FSM and stop request flag.
    // The stop flag is taken only in RUN and is consumed when RUN is left.
    // In IDLE, start has priority, so a stop arriving with it is dropped.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FFTC_IDLE;
            stop_pend <= 1'b0;
        end else begin
            case (state)
                FFTC_IDLE: begin
                    if (start) begin
                        state <= FFTC_RUN;
                    end
                end
                FFTC_RUN: begin
                    if (stop_pend && (in_cnt == '0)) begin
                        state     <= FFTC_DRAIN;
                        stop_pend <= 1'b0;
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                FFTC_DRAIN: begin
                    if (inflight == 3'd0) begin
                        state <= FFTC_IDLE;
                    end
                end
                default: begin
                    state     <= FFTC_IDLE;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Registered FFT input side.
    // fft_iaddr and fft_idata hold their last values between beats.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fft_ien   <= 1'b0;
            bus.fft_iaddr <= '0;
            bus.fft_idata <= '0;
        end else begin
            bus.fft_ien <= accept;
            if (accept) begin
                bus.fft_iaddr <= in_cnt;
                bus.fft_idata <= bus.s_data;
            end
        end
    end

    // Frame accounting on the output side.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 3'd0;
            frame_done <= 1'b0;
            frames_out <= 16'd0;
        end else begin
            inflight   <= inflight_next(inflight, in_done, out_done);
            frame_done <= out_done;
            if (out_done) begin
                frames_out <= frames_out + 16'd1;
            end
        end
    end

    // Output ordering check.
    // A mismatched beat still advances out_cnt, so later in-order beats do
    // not re-flag.
    // An error arriving in the same cycle as a start wins over the clear.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            err_order <= 1'b0;
        end else if (bus.fft_oen && (bus.fft_oaddr != out_cnt)) begin
            err_order <= 1'b1;
        end else if ((state == FFTC_IDLE) && start) begin
            err_order <= 1'b0;
        end
    end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer that feeds a streaming sample source into the pipelined FFT datapath (`fft_stage*` chain) and tracks frames in flight. It packs a valid/ready sample stream into N = 2^STAGES-point frames and drives the FFT `ien`/`iaddr`/`idata` inputs. It counts completed output frames from the FFT `oen`/`oaddr` stream and throttles input at frame boundaries so no more than MAX_INFLIGHT frames occupy the pipeline.

## Interface
- STAGES, default `` `TOTAL_STAGE `` (8): log2 of the FFT length N.
- CPLX_W, default `` `CPLX_WIDTH `` (32): complex sample width, {re, im}.
- MAX_INFLIGHT, default 2: maximum number of frames in flight, range 1..7.

Ports:
- iclk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; arms the controller from IDLE.
- stop  in  1  pulse; requests shutdown at the next frame boundary.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller accepts a sample this cycle.
- s_data  in  CPLX_W  input sample.
- fft_ien  out  1  FFT input enable.
- fft_iaddr  out  STAGES  FFT input sample index.
- fft_idata  out  CPLX_W  FFT input sample.
- fft_oen  in  1  FFT output valid.
- fft_oaddr  in  STAGES  FFT output index.
- busy  out  1  state is not IDLE.
- inflight  out  3  number of frames currently in flight.
- frame_done  out  1  one-cycle pulse per completed output frame.
- frames_out  out  16  count of completed output frames; wraps.
- err_order  out  1  sticky; an output index arrived out of sequence.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN when a stop request is pending and in_cnt==0.
  - DRAIN → IDLE when inflight==0.
  - `start` is ignored outside IDLE. `stop` is ignored in IDLE. In IDLE, if `start` and `stop` are asserted together, `start` wins and `stop` is dropped.
- Stop request: held in an internal flag, set by `stop` while in RUN and cleared on leaving RUN. A stop received mid-frame completes the current frame first.
- `s_ready` = RUN && !(in_cnt==0 && (inflight==MAX_INFLIGHT || stop_pend)). Once a frame has begun it is never throttled. Gaps from `s_valid` low are allowed; `fft_ien` qualifies every beat.
- Input counter in_cnt (STAGES bits): increments on each accepted beat and wraps N-1 → 0. Accepting the beat with in_cnt==N-1 increments inflight.
- Output counter out_cnt (STAGES bits): increments on each `fft_oen` beat and wraps. A beat with out_cnt==N-1 decrements inflight, pulses `frame_done`, and increments `frames_out` (mod 2^16).
- Output beats arriving in IDLE are still counted; inflight saturates at 0 and never underflows.
- Simultaneous inflight increment and decrement in the same cycle: net unchanged.
- Order check: `err_order` sets on any `fft_oen` beat with fft_oaddr != out_cnt. It is sticky and cleared only by an accepted `start` or by reset. out_cnt still advances on a mismatched beat.
- Width rules: all counters wrap modulo their width. inflight never exceeds MAX_INFLIGHT by construction.

## Timing
- Input path latency is 1 cycle. A beat accepted at edge t gives `fft_ien`=1 after t, with `fft_iaddr` = in_cnt before the increment and `fft_idata` = `s_data`, all registered.
- `fft_idata` and `fft_iaddr` hold their last values when `fft_ien`=0.
- `frame_done`, `frames_out` and inflight update at the edge that samples the last `fft_oen` beat.
- `s_ready` is combinational from registered state only; it has no dependence on `s_valid`.
- Reset, asynchronous, any time including mid-frame:
  - state=IDLE.
  - All counters, inflight, stop flag, `err_order`, `fft_ien` and `frame_done` = 0.
  - `fft_iaddr` and `fft_idata` = 0.
  - `s_ready`=0 and `busy`=0.
  - A partially fed frame is abandoned; the FFT pipeline is reset by the same `rst_n`.

## Structure
- `` `TOTAL_STAGE `` and `` `CPLX_WIDTH `` come from the shared `fft_inc.h`. State encodings (IDLE=0, RUN=1, DRAIN=2) are added to the same header as `` `FFTC_* `` defines.
- One sub-module, `fft_frame_cnt`: a STAGES-bit wrapping counter with `inc` input and `last` (count==N-1) output. It is instantiated twice, for the input side and the output side.
- Top-level integration: `fft_frame_ctrl` outputs → `fft_stage2` inputs; `fft_stage2` outputs → `fft_frame_ctrl` `fft_oen`/`fft_oaddr`.

## Test plan
All scenarios run with STAGES=3 (N=8) and MAX_INFLIGHT=2.
- Basic frame: `start`, then 8 back-to-back valid beats with data 0..7 → `fft_ien` for 8 cycles, each 1 cycle after acceptance, iaddr 0..7; inflight 0→1.
- Throttle: feed 3 frames with `fft_oen` held low → `s_ready`=0 after 16 accepts while inflight=2. Return 8 `fft_oen` beats with oaddr 0..7 → `frame_done` pulse, inflight=1, `s_ready` reasserts the next cycle.
- Mid-frame stop: `stop` after 3 of 8 beats → the remaining 5 beats are still accepted, then `s_ready`=0 and state=DRAIN. After the output frame returns: inflight=0, `busy`=0, frames_out=1.
- Simultaneous events: the last input beat and the last output beat in the same cycle with inflight=1 → inflight stays 1 and `frame_done`=1.
- Order error: output beats with oaddr 0,1,3 → `err_order`=1 from the third beat onward, held until the next `start`.
- Reset mid-frame: assert `rst_n` low after 5 accepts → every output reaches its reset value immediately, without waiting for a clock edge. After release and `start`, the next accepted beat has iaddr=0.
